multiport_memory_controller: RTL

Next-generation cell memory controller for the Lisp machine: a single-port synchronous word RAM shared by NUM_PORTS requesters through a round-robin arbiter with valid/ready request and one-cycle response pulses. On reset it runs a boot sequence that fills every word with BOOT_FILL, unless BYPASS_BOOT is set. It sits between the evaluator/GC masters and the cell store.

---
 rtl/multiport_memory_controller.sv | 137 +++++++++++++
 1 files changed

// File: rtl/multiport_memory_controller.sv
// Cell-store controller: one synchronous word RAM shared by N requesters.
// Round-robin grant, one-cycle response pulse, boot-time fill.
package lisp;
  typedef enum logic {BOOT, RUN} mc_state_t;
  localparam logic [7:0] TYPE_NUMBER = 8'h01;
endpackage

module mpmc_ram #(
  parameter int AW = 10,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] ram [0:(1<<AW)-1];

  always_ff @(posedge clk)
    if (we) ram[addr] <= wdata;

  // Write-first read port; holds when idle so data stays valid after the pulse.
  always_ff @(posedge clk or negedge rst)
    if (!rst)    rdata <= '0;
    else if (re) rdata <= we ? wdata : ram[addr];
endmodule

module multiport_memory_controller
  import lisp::*;
#(
  parameter int                    ADDR_WIDTH  = 10,
  parameter int                    DATA_WIDTH  = 16,
  parameter int                    NUM_PORTS   = 2,
  parameter int                    BYPASS_BOOT = 0,
  parameter logic [DATA_WIDTH-1:0] BOOT_FILL   = '0
) (
  input  logic                             clk,
  input  logic                             rst,
  output logic                             boot_done,
  input  logic [NUM_PORTS-1:0]             req_valid,
  output logic [NUM_PORTS-1:0]             req_ready,
  input  logic [NUM_PORTS-1:0]             req_write,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_PORTS-1:0]             rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int PW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  mc_state_t             state;
  mc_state_t             state_nx;
  logic [ADDR_WIDTH:0]   fill_cnt;
  logic                  fill_last;
  logic [PW-1:0]         ptr;
  logic [PW-1:0]         gnt;
  logic [PW-1:0]         cand;
  logic                  hit;
  logic                  ram_we;
  logic                  ram_re;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;

  assign fill_last = (fill_cnt == (ADDR_WIDTH+1)'(DEPTH-1));
  assign boot_done = (state == RUN);

  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= (BYPASS_BOOT != 0) ? RUN : BOOT;
    else      state <= state_nx;

  always_comb begin
    state_nx = state;
    unique case (state)
      BOOT: if (fill_last) state_nx = RUN;
      RUN:  state_nx = RUN;
    endcase
  end

  // First valid port at or after ptr, wrapping.
  always_comb begin
    hit  = 1'b0;
    gnt  = '0;
    cand = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = PW'((int'(ptr) + i) % NUM_PORTS);
      if (!hit && req_valid[cand]) begin
        hit = 1'b1;
        gnt = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_addr  = fill_cnt[ADDR_WIDTH-1:0];
    ram_wdata = BOOT_FILL;
    unique case (state)
      BOOT: ram_we = 1'b1;
      RUN: begin
        req_ready[gnt] = hit;
        ram_re    = hit;
        ram_we    = hit & req_write[gnt];
        ram_addr  = req_addr[int'(gnt)*ADDR_WIDTH +: ADDR_WIDTH];
        ram_wdata = req_wdata[int'(gnt)*DATA_WIDTH +: DATA_WIDTH];
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      ptr       <= '0;
      fill_cnt  <= '0;
      rsp_valid <= '0;
    end else begin
      if (state == BOOT) fill_cnt <= fill_cnt + 1'b1;
      rsp_valid <= req_ready;
      if (ram_re) ptr <= PW'((int'(gnt) + 1) % NUM_PORTS);
    end

  mpmc_ram #(
    .AW(ADDR_WIDTH),
    .DW(DATA_WIDTH)
  ) ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (rsp_rdata)
  );
endmodule
